// File: rtl/mem_access_controller.sv
// MEM-stage bridge: splits each 32-bit load/store into two 16-bit SRAM accesses,
// low half first, then holds the pipeline through a settle window before completing.
module mem_access_controller #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic        sram_we_n,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [2:0] {IDLE, LOW, HIGH, WAIT, DONE} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES - 1);

  state_t      state;
  logic        is_wr;
  logic [16:0] idx_q;
  logic [15:0] data_hi;
  logic [15:0] hold_lo;
  logic [3:0]  wait_cnt;
  logic [16:0] idx_in;

  assign idx_in = 17'((address - BASE_ADDR) >> 2);
  assign ready  = (state == DONE) || (state == IDLE && !wr_en && !rd_en);

  // SRAM pins are registered: each branch loads the values the next state drives.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      is_wr       <= 1'b0;
      idx_q       <= '0;
      data_hi     <= '0;
      hold_lo     <= '0;
      wait_cnt    <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
    end else begin
      sram_addr   <= '0;
      sram_we_n   <= 1'b1;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      case (state)
        IDLE: if (wr_en || rd_en) begin
          is_wr       <= wr_en;
          idx_q       <= idx_in;
          data_hi     <= write_data[31:16];
          state       <= LOW;
          sram_addr   <= {idx_in, 1'b0};
          sram_we_n   <= !wr_en;
          sram_dq_oe  <= wr_en;
          sram_dq_out <= wr_en ? write_data[15:0] : 16'h0;
        end
        LOW: begin
          if (!is_wr) hold_lo <= sram_dq_in;
          state       <= HIGH;
          sram_addr   <= {idx_q, 1'b1};
          sram_we_n   <= !is_wr;
          sram_dq_oe  <= is_wr;
          sram_dq_out <= is_wr ? data_hi : 16'h0;
        end
        HIGH: begin
          // Read result is assembled here so it is already stable through WAIT and DONE.
          if (!is_wr) read_data <= {sram_dq_in, hold_lo};
          if (WAIT_CYCLES == 0) begin
            state <= DONE;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= DONE;
          else wait_cnt <= wait_cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
